// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential nibble multiplier controller:
// FSM state encoding, nibble width and the partial-product shift helper.
package mul_seq_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Issue index idx walks the a-nibble (inner, i) fastest, then the
   // b-nibble (outer, j); the partial product a_i*b_j weighs 4*(i+j) bits.
   function automatic int unsigned nib_shift(input int unsigned idx,
                                             input int unsigned nib);
      return NIB_W * ((idx % nib) + (idx / nib));
   endfunction

endpackage

// File: rtl/mul_seq_acc.sv
// Shift-accumulate register for the sequential multiplier: adds an 8-bit
// partial product, zero-extended to 2*WIDTH bits and left-shifted, into a
// running sum. Clear takes priority over add.
module mul_seq_acc #(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr_i,
   input  logic                         add_i,
   input  logic [$clog2(2*WIDTH)-1:0]   shift_i,
   input  logic [7:0]                   part_i,
   output logic [2*WIDTH-1:0]           acc_sum_o
);

   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_d;
   logic [2*WIDTH-1:0] term;

   // Next accumulator value; also exported so the controller can capture
   // the final sum on the same edge the last partial product lands.
   always_comb begin
      term  = (2*WIDTH)'(part_i) << shift_i;
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (add_i) begin
         acc_d = acc_q + term;
      end
   end

   // Accumulator register, cleared asynchronously by the active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_sum_o = acc_d;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer computing a WIDTH x WIDTH unsigned product through an external
// registered 4x4 multiplier. One nibble pair is issued per enabled cycle;
// returned 8-bit products are shift-accumulated one cycle later and the
// 2*WIDTH-bit result is offered on a valid/ready output.
module mul_seq_ctrl
   import mul_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   output logic [3:0]           mul_a,
   output logic [3:0]           mul_b,
   input  logic [7:0]           mul_p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_p
);

   localparam int NIB   = WIDTH / NIB_W;
   localparam int NN    = NIB * NIB;
   localparam int IDX_W = (NN > 1) ? $clog2(NN) : 1;
   localparam int SH_W  = $clog2(2*WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);

   state_e               state_q, state_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 pend_q, pend_d;
   logic [SH_W-1:0]      shift_q, shift_d;
   logic                 out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0]   out_p_q, out_p_d;

   logic                 issue;
   logic                 accept;
   logic                 acc_clr;
   logic [2*WIDTH-1:0]   acc_sum;
   int unsigned          i_n;
   int unsigned          j_n;

   assign issue    = (state_q == ST_ISSUE) && ena;
   assign accept   = (state_q == ST_IDLE) && ena && in_valid;
   assign in_ready = (state_q == ST_IDLE) && ena;

   // Nibble selection for the current issue; the multiplier sees zeros
   // whenever nothing is being issued.
   always_comb begin
      i_n   = 32'(idx_q) % NIB;
      j_n   = 32'(idx_q) / NIB;
      mul_a = '0;
      mul_b = '0;
      if (issue) begin
         mul_a = 4'(a_q >> (NIB_W * i_n));
         mul_b = 4'(b_q >> (NIB_W * j_n));
      end
   end

   // Control FSM: accept, issue NIB*NIB pairs, drain the last product,
   // then hold the result until the consumer takes it.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      idx_d       = idx_q;
      pend_d      = 1'b0;
      shift_d     = shift_q;
      out_valid_d = out_valid_q;
      out_p_d     = out_p_q;
      acc_clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               a_d     = in_a;
               b_d     = in_b;
               idx_d   = '0;
               acc_clr = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ena) begin
               pend_d  = 1'b1;
               shift_d = SH_W'(nib_shift(32'(idx_q), NIB));
               if (idx_q == IDX_LAST) begin
                  state_d = ST_DRAIN;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            out_valid_d = 1'b1;
            out_p_d     = acc_sum;
            state_d     = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset aborts any operation in flight immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         idx_q       <= '0;
         pend_q      <= 1'b0;
         shift_q     <= '0;
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         idx_q       <= idx_d;
         pend_q      <= pend_d;
         shift_q     <= shift_d;
         out_valid_q <= out_valid_d;
         out_p_q     <= out_p_d;
      end
   end

   // The multiplier never stalls, so a pending product is added whether
   // or not ena is high this cycle.
   mul_seq_acc #(
      .WIDTH (WIDTH)
   ) u_acc (
      .clk       (clk),
      .rst       (rst),
      .clr_i     (acc_clr),
      .add_i     (pend_q),
      .shift_i   (shift_q),
      .part_i    (mul_p),
      .acc_sum_o (acc_sum)
   );

   assign out_valid = out_valid_q;
   assign out_p     = out_p_q;

endmodule
